// File: rtl/arith_pkg.sv
// Shared arithmetic-pipeline types and constants.
// Used by the sequential multiplier and its adder datapath.
package arith_pkg;

  localparam int WIDTH_8 = 8;
  localparam int PROD_W  = 2 * WIDTH_8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/CSkipA8.sv
// 8-bit carry-skip adder: two 4-bit ripple blocks,
// each with a block-propagate bypass of its carry.
module CSkipA8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] p;
  logic [7:0] g;
  logic [8:0] c;
  logic       skip_lo;
  logic       skip_hi;
  logic       rip_lo;
  logic       rip_hi;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    c       = '0;
    rip_lo  = 1'b0;
    rip_hi  = 1'b0;
    skip_lo = &p[3:0];
    skip_hi = &p[7:4];
    c[0]    = cin;
    for (int i = 0; i < 4; i++)
      c[i+1] = g[i] | (p[i] & c[i]);
    rip_lo = c[4];
    // block carry bypasses the ripple chain when all bits propagate
    c[4] = skip_lo ? cin : rip_lo;
    for (int i = 4; i < 8; i++)
      c[i+1] = g[i] | (p[i] & c[i]);
    rip_hi = c[8];
    c[8] = skip_hi ? c[4] : rip_hi;
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/seq_mul8.sv
// Sequential 8x8 unsigned shift-and-add multiplier
// with ready/valid handshakes on both sides.
module seq_mul8
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  if (WIDTH != WIDTH_8) begin : g_bad_width
    $error("seq_mul8 supports WIDTH=8 only");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t            state;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  mcand;
  logic [CNT_W-1:0]  cnt;

  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic [WIDTH-1:0]  acc_n;
  logic [WIDTH-1:0]  q_n;
  logic [PROD_W-1:0] prod_n;

  CSkipA8 u_add (
    .a    (acc),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // one partial-product step: add when q[0] is set, then shift right
  always_comb begin
    acc_n = {1'b0, acc[WIDTH-1:1]};
    q_n   = {acc[0], q[WIDTH-1:1]};
    if (q[0]) begin
      acc_n = {cout, sum[WIDTH-1:1]};
      q_n   = {sum[0], q[WIDTH-1:1]};
    end
    prod_n = {acc_n, q_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      acc       <= '0;
      q         <= '0;
      mcand     <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= a;
            q        <= b;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_n;
          q   <= q_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            product   <= prod_n;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul8.sv
// Scoreboard bench for seq_mul8: directed cases plus
// randomized operands with random output back-pressure.
module tb_seq_mul8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] product;

  seq_mul8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int c;
  } exp_t;

  exp_t sbq[$];
  int   rises[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   prev_ov = 1'b0;
  bit   rnd_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic flag(input string n);
    checks++;
    failures++;
    $display("FAIL %s: got event want none (cycle %0d)", n, cyc);
  endtask

  // monitor: latency on each rising out_valid, value on each handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        rises.push_back(cyc);
        if (sbq.size() == 0) flag("spurious_valid");
        else chk("latency", cyc - sbq[0].c, 8);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          flag("unexpected_product");
        end else begin
          e = sbq.pop_front();
          chk("product", int'(product), e.p);
        end
      end
      prev_ov = out_valid;
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #2;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    @(posedge clk);
    #2;
    a = x;
    b = y;
    in_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.p = int'(x) * int'(y);
        e.c = cyc + 1;
        sbq.push_back(e);
        return;
      end
    end
    flag("accept_timeout");
  endtask

  task automatic idle();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    flag("out_valid_timeout");
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sbq.size() == 0) return;
    end
    flag("drain_timeout");
    sbq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    logic [7:0] x;
    logic [7:0] y;

    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_product", int'(product), 0);
    @(negedge clk);
    rst_n = 1'b1;

    send(8'd13, 8'd11);
    idle();
    wait_ov();
    chk("p_13x11", int'(product), 16'h008F);
    @(negedge clk);
    chk("idle_ov", int'(out_valid), 0);
    chk("idle_ready", int'(in_ready), 1);

    send(8'd255, 8'd255);
    idle();
    drain();
    send(8'd0, 8'd200);
    idle();
    drain();
    send(8'd1, 8'd128);
    idle();
    drain();

    // back-pressure: result must hold, new operands ignored
    out_ready = 1'b0;
    send(8'd7, 8'd9);
    idle();
    wait_ov();
    @(posedge clk);
    #2;
    a = 8'd2;
    b = 8'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_product", int'(product), 16'h003F);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    send(8'd2, 8'd2);
    idle();
    drain();

    // reset in the middle of RUN
    send(8'd100, 8'd100);
    idle();
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_product", int'(product), 0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    send(8'd3, 8'd5);
    idle();
    drain();

    // back-to-back with in_valid held high
    r0 = rises.size();
    send(8'd17, 8'd19);
    send(8'd200, 8'd3);
    send(8'd99, 8'd101);
    idle();
    drain();
    if (rises.size() != r0 + 3) begin
      chk("b2b_count", rises.size() - r0, 3);
    end else begin
      chk("b2b_gap1", rises[r0+1] - rises[r0], 10);
      chk("b2b_gap2", rises[r0+2] - rises[r0+1], 10);
    end

    // randomized operands and back-pressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) x = 8'd255;
      if ($urandom_range(0, 9) == 0) y = 8'd0;
      send(x, y);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
      end
    end
    idle();
    drain();
    rnd_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
